// File: rtl/numled_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : numled_scan_ctrl_pkg
// Description : Shared constants for the NUMLED seven-segment scan path.
// Revision    : 1.0 - initial release
// ============================================================================
package numled_scan_ctrl_pkg;

    localparam int DEVICE_NUM_NUMLED_EN = 8;

    // Glyphs are {cg,cf,ce,cd,cc,cb,ca}, active low.
    localparam logic [6:0] NUMLED_SEG_0   = 7'b1000000;
    localparam logic [6:0] NUMLED_SEG_1   = 7'b1111001;
    localparam logic [6:0] NUMLED_SEG_2   = 7'b0100100;
    localparam logic [6:0] NUMLED_SEG_3   = 7'b0110000;
    localparam logic [6:0] NUMLED_SEG_4   = 7'b0011001;
    localparam logic [6:0] NUMLED_SEG_5   = 7'b0010010;
    localparam logic [6:0] NUMLED_SEG_6   = 7'b0000010;
    localparam logic [6:0] NUMLED_SEG_7   = 7'b1111000;
    localparam logic [6:0] NUMLED_SEG_8   = 7'b0000000;
    localparam logic [6:0] NUMLED_SEG_9   = 7'b0010000;
    localparam logic [6:0] NUMLED_SEG_A   = 7'b0001000;
    localparam logic [6:0] NUMLED_SEG_B   = 7'b0000011;
    localparam logic [6:0] NUMLED_SEG_C   = 7'b1000110;
    localparam logic [6:0] NUMLED_SEG_D   = 7'b0100001;
    localparam logic [6:0] NUMLED_SEG_E   = 7'b0000110;
    localparam logic [6:0] NUMLED_SEG_F   = 7'b0001110;
    localparam logic [6:0] NUMLED_SEG_OFF = 7'b1111111;

endpackage
`default_nettype wire

// File: rtl/numled_hex7seg.sv
`default_nettype none
// ============================================================================
// Module      : numled_hex7seg
// Description : Combinational hex nibble to active-low seven-segment glyph.
// Revision    : 1.0 - initial release
// ============================================================================
module numled_hex7seg
    import numled_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = NUMLED_SEG_OFF;
        case (nibble)
            4'h0: seg = NUMLED_SEG_0;
            4'h1: seg = NUMLED_SEG_1;
            4'h2: seg = NUMLED_SEG_2;
            4'h3: seg = NUMLED_SEG_3;
            4'h4: seg = NUMLED_SEG_4;
            4'h5: seg = NUMLED_SEG_5;
            4'h6: seg = NUMLED_SEG_6;
            4'h7: seg = NUMLED_SEG_7;
            4'h8: seg = NUMLED_SEG_8;
            4'h9: seg = NUMLED_SEG_9;
            4'hA: seg = NUMLED_SEG_A;
            4'hB: seg = NUMLED_SEG_B;
            4'hC: seg = NUMLED_SEG_C;
            4'hD: seg = NUMLED_SEG_D;
            4'hE: seg = NUMLED_SEG_E;
            4'hF: seg = NUMLED_SEG_F;
            default: seg = NUMLED_SEG_OFF;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/numled_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : numled_scan_ctrl
// Description : Time-multiplexed digit scanner with per-frame snapshot,
//               guard-cycle blanking and leading-zero suppression.
// Revision    : 1.0 - initial release
// ============================================================================
module numled_scan_ctrl
    import numled_scan_ctrl_pkg::*;
#(
    parameter int DIGITS   = DEVICE_NUM_NUMLED_EN,
    parameter int SCAN_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  light,
    input  logic [4*DIGITS-1:0]   num_in,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     led_en,
    output logic                  led_ca,
    output logic                  led_cb,
    output logic                  led_cc,
    output logic                  led_cd,
    output logic                  led_ce,
    output logic                  led_cf,
    output logic                  led_cg,
    output logic                  led_dp,
    output logic                  frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_shadow;

    logic                w_cnt_last;
    logic                w_idx_last;
    logic [3:0]          w_nibble;
    logic [6:0]          w_glyph;
    logic [DIGITS-1:0]   w_nib_zero;
    logic [DIGITS-1:0]   w_upper_zero;
    logic                w_blank;

    assign w_cnt_last = (r_cnt == CNT_W'(SCAN_DIV - 1));
    assign w_idx_last = (r_idx == IDX_W'(DIGITS - 1));
    assign w_nibble   = r_shadow[4*r_idx +: 4];

    // w_upper_zero[i] is set when digit i and every digit to its left are zero.
    for (genvar i = 0; i < DIGITS; i++) begin : g_lz
        assign w_nib_zero[i] = (r_shadow[4*i +: 4] == 4'h0);
        if (i == DIGITS - 1) begin : g_top
            assign w_upper_zero[i] = w_nib_zero[i];
        end else begin : g_chain
            assign w_upper_zero[i] = w_nib_zero[i] & w_upper_zero[i+1];
        end
    end

    assign w_blank = blank_lz && (r_idx != '0) && w_upper_zero[r_idx];

    numled_hex7seg u_hex7seg (
        .nibble (w_nibble),
        .seg    (w_glyph)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shadow   <= '0;
            led_en     <= '1;
            {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca} <= NUMLED_SEG_OFF;
            led_dp     <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            if (w_cnt_last) begin
                r_cnt <= '0;
                r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // One snapshot per frame keeps mid-frame num_in updates from tearing.
            if ((r_cnt == '0) && (r_idx == '0)) begin
                r_shadow <= num_in;
            end

            // cnt==0 is the inter-digit guard; it also hides the stale decode
            // in the slot where a fresh snapshot is being taken.
            led_en <= (light && (r_cnt != '0)) ? ~(DIGITS'(1) << r_idx) : '1;

            {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca} <=
                w_blank ? NUMLED_SEG_OFF : w_glyph;
            led_dp     <= w_blank ? 1'b1 : ~dp_mask[r_idx];
            frame_done <= w_cnt_last && w_idx_last;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_numled_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_numled_scan_ctrl
// Description : Self-checking bench: frame-position model plus literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_numled_scan_ctrl;

    localparam int DIGITS   = 8;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic        clk;
    logic        rst_n;
    logic        light;
    logic [31:0] num_in;
    logic [7:0]  dp_mask;
    logic        blank_lz;
    logic [7:0]  led_en;
    logic        led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    numled_scan_ctrl #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .light      (light),
        .num_in     (num_in),
        .dp_mask    (dp_mask),
        .blank_lz   (blank_lz),
        .led_en     (led_en),
        .led_ca     (led_ca),
        .led_cb     (led_cb),
        .led_cc     (led_cc),
        .led_cd     (led_cd),
        .led_ce     (led_ce),
        .led_cf     (led_cf),
        .led_cg     (led_cg),
        .led_dp     (led_dp),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg;
    assign seg = {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference glyph table, {cg..ca} active low.
    logic [6:0] glyph [16];
    initial begin
        glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
        glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
        glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
        glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;
    end

    // Model: pos counts released edges; slot, digit and frame follow by division.
    int          pos = 0;
    logic [31:0] m_shadow;
    logic [7:0]  exp_en;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_fd, seg_valid, started = 1'b0;

    always @(posedge clk) begin
        int slot, dig;
        logic lz;
        if (!rst_n) begin
            pos = 0; m_shadow = '0;
            exp_en = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
            seg_valid = 1'b1;
        end else begin
            slot = pos % SCAN_DIV;
            dig  = (pos / SCAN_DIV) % DIGITS;
            exp_en    = (light && slot != 0) ? ~(8'd1 << dig) : 8'hFF;
            exp_fd    = ((pos % FRAME) == FRAME - 1);
            lz        = blank_lz && dig != 0 && ((m_shadow >> (4 * dig)) == 32'd0);
            exp_seg   = lz ? 7'h7F : glyph[(m_shadow >> (4 * dig)) & 32'hF];
            exp_dp    = lz ? 1'b1 : ~dp_mask[dig];
            seg_valid = (slot != 0);
            if ((pos % FRAME) == 0) m_shadow = num_in;
            pos++;
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("led_en", {24'd0, led_en}, {24'd0, exp_en});
            chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
            if (seg_valid) begin
                chk("segments", {25'd0, seg}, {25'd0, exp_seg});
                chk("led_dp", {31'd0, led_dp}, {31'd0, exp_dp});
            end
        end
    end

    initial begin
        rst_n = 1'b0; light = 1'b1; dp_mask = 8'h00; blank_lz = 1'b0;
        num_in = 32'h12345678;
        repeat (3) begin
            @(negedge clk);
            chk("rst_en", {24'd0, led_en}, 32'hFF);
            chk("rst_seg", {25'd0, seg}, 32'h7F);
            chk("rst_fd", {31'd0, frame_done}, 32'h0);
        end
        rst_n = 1'b1;
        for (int n = 1; n <= 260; n++) begin
            @(negedge clk);
            case (n)
                1:   chk("lit_guard0", {24'd0, led_en}, 32'hFF);
                2: begin
                    chk("lit_d0_en", {24'd0, led_en}, 32'hFE);
                    chk("lit_d0_8", {25'd0, seg}, 32'h00);
                end
                4:   chk("lit_d0_end", {24'd0, led_en}, 32'hFE);
                5: begin
                    chk("lit_guard1", {24'd0, led_en}, 32'hFF);
                    num_in = 32'h0123ABCD;
                end
                32:  chk("lit_fd", {31'd0, frame_done}, 32'h1);
                33:  chk("lit_fd_once", {31'd0, frame_done}, 32'h0);
                34:  chk("lit_glyph_D", {25'd0, seg}, 32'h21);
                40:  num_in = 32'h11111111;
                50: begin
                    chk("lit_d4_en", {24'd0, led_en}, 32'hEF);
                    chk("lit_glyph_3", {25'd0, seg}, 32'h30);
                end
                78: begin
                    chk("lit_d3_1", {25'd0, seg}, 32'h79);
                    num_in = 32'h22222222;
                end
                86:  chk("lit_notear", {25'd0, seg}, 32'h79);
                98:  chk("lit_next_2", {25'd0, seg}, 32'h24);
                100: begin
                    blank_lz = 1'b1;
                    num_in = 32'h00000040;
                end
                130: chk("lit_lz_d0", {25'd0, seg}, 32'h40);
                134: chk("lit_lz_d1", {25'd0, seg}, 32'h19);
                140: num_in = 32'h0;
                158: begin
                    chk("lit_lz_d7_en", {24'd0, led_en}, 32'h7F);
                    chk("lit_lz_d7", {25'd0, seg}, 32'h7F);
                end
                162: chk("lit_zero_d0", {25'd0, seg}, 32'h40);
                166: chk("lit_zero_d1", {25'd0, seg}, 32'h7F);
                190: begin
                    light = 1'b0;
                    blank_lz = 1'b0;
                end
                194: chk("lit_dark", {24'd0, led_en}, 32'hFF);
                224: begin
                    chk("lit_fd_dark", {31'd0, frame_done}, 32'h1);
                    light = 1'b1;
                    dp_mask = 8'h04;
                end
                234: begin
                    chk("lit_d2_en", {24'd0, led_en}, 32'hFB);
                    chk("lit_dp_on", {31'd0, led_dp}, 32'h0);
                end
                238: chk("lit_dp_off", {31'd0, led_dp}, 32'h1);
                default: ;
            endcase
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
